// File: rtl/jk_pkg.sv
// Shared constants and FSM state type for the JK bank arbiter.
// Command encoding is {j,k}.
package jk_pkg;
   localparam int unsigned WIDTH = 8;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_TGL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      ACK   = 2'd2
   } state_t;
endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
// qbar is derived from q so the two can never disagree, even during reset.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            CMD_HOLD: q <= q;
            CMD_CLR:  q <= 1'b0;
            CMD_SET:  q <= 1'b1;
            CMD_TGL:  q <= ~q;
            default:  q <= q;
         endcase
      end
   end

   assign qbar = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter between two requesters sharing a bank of JK cells.
// Each operation runs IDLE -> APPLY -> ACK; q updates on the APPLY->ACK edge.
module jk_bank_arbiter
   import jk_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [1:0]       cmd_a,
   input  logic [WIDTH-1:0] mask_a,
   input  logic             req_b,
   input  logic [1:0]       cmd_b,
   input  logic [WIDTH-1:0] mask_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             last_grant
);

   state_t           state;
   logic [1:0]       cmd_l;
   logic [WIDTH-1:0] mask_l;
   logic             grant_b;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;

   // B wins when alone, or when both ask and A was served last.
   always_comb begin
      grant_b = req_b & (~req_a | ~last_grant);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cmd_l      <= '0;
         mask_l     <= '0;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  cmd_l      <= grant_b ? cmd_b : cmd_a;
                  mask_l     <= grant_b ? mask_b : mask_a;
                  last_grant <= grant_b;
                  busy       <= 1'b1;
                  state      <= APPLY;
               end
            end
            APPLY: begin
               ack_a <= ~last_grant;
               ack_b <= last_grant;
               state <= ACK;
            end
            ACK: begin
               ack_a <= 1'b0;
               ack_b <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Cells see a non-hold command only during APPLY and only where masked in.
   always_comb begin
      j_vec = '0;
      k_vec = '0;
      if (state == APPLY) begin
         j_vec = mask_l & {WIDTH{cmd_l[1]}};
         k_vec = mask_l & {WIDTH{cmd_l[0]}};
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .j    (j_vec[i]),
         .k    (k_vec[i]),
         .q    (q[i]),
         .qbar (qbar[i])
      );
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_jk_bank_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [1:0] cmd_a = 2'b00, cmd_b = 2'b00;
   logic [7:0] mask_a = 8'h00, mask_b = 8'h00;
   logic       ack_a, ack_b, busy, last_grant;
   logic [7:0] q, qbar;

   int checks = 0;
   int errors = 0;

   jk_bank_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .cmd_a      (cmd_a),
      .mask_a     (mask_a),
      .req_b      (req_b),
      .cmd_b      (cmd_b),
      .mask_b     (mask_b),
      .ack_a      (ack_a),
      .ack_b      (ack_b),
      .q          (q),
      .qbar       (qbar),
      .busy       (busy),
      .last_grant (last_grant)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      #1;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
      checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h exp %h", qbar, 8'hFF); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b exp 1", last_grant); end
      checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {ack_a, ack_b}); end
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_set;
      req_a = 1'b1; cmd_a = 2'b10; mask_a = 8'h0F;
      tick; // E0
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy_e0 got %b exp 1", busy); end
      checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL set_ack_e0 got %b exp 0", ack_a); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL set_q_e0 got %h exp %h", q, 8'h00); end
      checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL set_grant got %b exp 0", last_grant); end
      cmd_a = 2'b11; mask_a = 8'hFF; // must be ignored after E0
      tick; // E1
      checks++; if (q !== 8'h0F) begin errors++; $display("FAIL set_q_e1 got %h exp %h", q, 8'h0F); end
      checks++; if (qbar !== 8'hF0) begin errors++; $display("FAIL set_qbar_e1 got %h exp %h", qbar, 8'hF0); end
      checks++; if ({ack_a, ack_b} !== 2'b10) begin errors++; $display("FAIL set_acks_e1 got %b exp 10", {ack_a, ack_b}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy_e1 got %b exp 1", busy); end
      req_a = 1'b0;
      tick; // E2
      checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL set_ack_e2 got %b exp 0", ack_a); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_busy_e2 got %b exp 0", busy); end
      checks++; if (q !== 8'h0F) begin errors++; $display("FAIL set_q_e2 got %h exp %h", q, 8'h0F); end
   endtask

   task automatic test_toggle_clear;
      req_b = 1'b1; cmd_b = 2'b11; mask_b = 8'hFF;
      tick;
      checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL tgl_grant got %b exp 1", last_grant); end
      tick;
      checks++; if (q !== 8'hF0) begin errors++; $display("FAIL tgl_q got %h exp %h", q, 8'hF0); end
      checks++; if ({ack_a, ack_b} !== 2'b01) begin errors++; $display("FAIL tgl_acks got %b exp 01", {ack_a, ack_b}); end
      req_b = 1'b0;
      tick;
      req_a = 1'b1; cmd_a = 2'b01; mask_a = 8'h30;
      tick;
      tick;
      checks++; if (q !== 8'hC0) begin errors++; $display("FAIL clr_q got %h exp %h", q, 8'hC0); end
      checks++; if (qbar !== 8'h3F) begin errors++; $display("FAIL clr_qbar got %h exp %h", qbar, 8'h3F); end
      checks++; if ({ack_a, ack_b} !== 2'b10) begin errors++; $display("FAIL clr_acks got %b exp 10", {ack_a, ack_b}); end
      req_a = 1'b0;
      tick;
   endtask

   task automatic test_null_op;
      int ack_cnt = 0;
      req_b = 1'b1; cmd_b = 2'b11; mask_b = 8'h65; // C0 ^ 65 = A5
      tick;
      tick;
      checks++; if (q !== 8'hA5) begin errors++; $display("FAIL null_setup_q got %h exp %h", q, 8'hA5); end
      req_b = 1'b0;
      tick;
      req_a = 1'b1; cmd_a = 2'b01; mask_a = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (ack_a) begin
            ack_cnt++;
            req_a = 1'b0;
         end
      end
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL null_ack_count got %0d exp 1", ack_cnt); end
      checks++; if (q !== 8'hA5) begin errors++; $display("FAIL null_q got %h exp %h", q, 8'hA5); end
      req_a = 1'b0;
   endtask

   task automatic test_abort;
      req_a = 1'b1; cmd_a = 2'b10; mask_a = 8'hFF;
      tick; // E0, now in APPLY
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_q got %h exp %h", q, 8'h00); end
      checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL abort_qbar got %h exp %h", qbar, 8'hFF); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL abort_last_grant got %b exp 1", last_grant); end
      tick;
      checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL abort_no_ack got %b exp 00", {ack_a, ack_b}); end
      rst = 1'b0;
      tick; // request still held, re-served
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_reserve_busy got %b exp 1", busy); end
      tick;
      checks++; if (q !== 8'hFF) begin errors++; $display("FAIL abort_reserve_q got %h exp %h", q, 8'hFF); end
      checks++; if (ack_a !== 1'b1) begin errors++; $display("FAIL abort_reserve_ack got %b exp 1", ack_a); end
      req_a = 1'b0;
      tick;
   endtask

   task automatic test_back_to_back;
      logic exp_b = 1'b0;
      logic exp_q0 = 1'b0;
      int n_acks = 0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req_a = 1'b1; cmd_a = 2'b11; mask_a = 8'h01;
      req_b = 1'b1; cmd_b = 2'b11; mask_b = 8'h01;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (i == 0) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_first_edge_busy got %b exp 1", busy); end
         end
         checks++; if (ack_a && ack_b) begin errors++; $display("FAIL rr_ack_overlap got %b exp not 11", {ack_a, ack_b}); end
         if (ack_a || ack_b) begin
            exp_q0 = ~exp_q0;
            checks++; if (ack_b !== exp_b) begin errors++; $display("FAIL rr_order got ack_b=%b exp %b", ack_b, exp_b); end
            checks++; if (last_grant !== exp_b) begin errors++; $display("FAIL rr_last_grant got %b exp %b", last_grant, exp_b); end
            checks++; if (q !== {7'b0, exp_q0}) begin errors++; $display("FAIL rr_q got %h exp %h", q, {7'b0, exp_q0}); end
            exp_b = ~exp_b;
            n_acks++;
         end
      end
      checks++; if (n_acks !== 4) begin errors++; $display("FAIL rr_ack_count got %0d exp 4", n_acks); end
      req_a = 1'b0;
      req_b = 1'b0;
      tick;
      tick;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy got %b exp 0", busy); end
   endtask

   initial begin
      test_reset;
      test_set;
      test_toggle_clear;
      test_null_op;
      test_abort;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
